hc595_driver: RTL and testbench
===============================

# hc595_driver

Serial transmitter that shifts a parallel word out to a chain of 74xx595 shift registers over pins SER/SRCLK/RCLK, then pulses the storage latch. It is the driving end of the 595 serial interface, used by the CPU's output-port and display logic to update the 595 outputs with one load strobe. All outputs are registered. The pin waveforms match what the 595 chip model expects.

## Interface
Parameters:
- WIDTH, 8: bits per frame (total 595 chain length); ≥1
- DIV, 2: clk cycles per SRCLK/RCLK half-period; ≥1

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- data  in  WIDTH  word to transmit, sampled only on an accepted load
- load  in  1  start request; accepted on a rising clk edge when busy=0
- busy  out  1  frame in progress; load ignored while high
- done  out  1  one-cycle pulse after frame completes (RCLK has fallen)
- ser  out  1  595 SER (serial data), MSB first
- srclk  out  1  595 SRCLK (shift clock); 595 shifts on its rising edge
- rclk  out  1  595 RCLK (storage latch clock); outputs update on its rising edge

## Operation
- States: IDLE, SETUP, HIGH, LATCH. Internal: shift register [WIDTH], bit counter, divider counter (0..DIV-1).
- IDLE: srclk=0, rclk=0, busy=0. On edge with load=1: capture data, ser<=data[WIDTH-1], busy<=1, bit counter<=0, go SETUP.
- SETUP: srclk=0 for DIV cycles, ser held stable; then srclk<=1, go HIGH.
- HIGH: srclk=1 for DIV cycles. At the end:
  - If bits remain: srclk<=0, shift left, ser<=next bit, go SETUP.
  - After bit WIDTH-1: srclk<=0, rclk<=1, go LATCH.
- LATCH: rclk=1 for DIV cycles; then rclk<=0, busy<=0, done<=1 for one cycle, go IDLE.
- ser changes only on the edge where srclk falls or busy rises. It is never changed on the edge where srclk rises. Setup and hold at the 595 are each ≥DIV cycles.
- ser holds the last transmitted bit (LSB) after the frame until the next load.
- The 595 latch is updated only on a complete frame. rclk never pulses for a partial frame.

## Timing
- Reset values: ser=0, srclk=0, rclk=0, busy=0, done=0. State IDLE, counters 0.
- Reset mid-frame: all outputs go to reset values immediately (asynchronously). The frame is abandoned with no rclk pulse, so the 595 outputs keep the previous word. The first load after reset deassertion starts a fresh frame.
- Latency: load edge → busy=1 and ser valid on that same edge. First srclk rising edge comes DIV cycles later.
- Busy duration: 2·DIV·WIDTH + DIV cycles. For WIDTH=8, DIV=2 this is 34 cycles. done is high in the cycle after busy falls.
- load asserted while busy=1 is dropped, not queued. load in the same cycle as done=1 is accepted, giving back-to-back frames with one idle cycle.
- load held high continuously gives one frame per 2·DIV·WIDTH+DIV+1 cycles, re-sampling data each time.
- DIV=1 is allowed: srclk toggles every cycle, with a 1-cycle rclk pulse.

## Test plan
- Reset: assert reset mid-run → ser, srclk, rclk, busy, done all 0 without a clock edge. Release reset → IDLE, no activity.
- Single frame, WIDTH=8, DIV=2, data=8'hA5 → sampling ser at each srclk rising edge gives 1,0,1,0,0,1,0,1. Exactly 8 srclk rises. rclk is high for 2 cycles after the last srclk fall. busy is high for 34 cycles. done pulses once. A 595 model then shows 8'hA5.
- Load while busy: pulse load with 8'h3C at cycle 10 of an 8'hFF frame → frame completes as 8'hFF, no second frame, total 8 srclk rises.
- Back-to-back: load=1 held with data 8'h01 then 8'h80 → two frames separated by exactly one idle cycle. The 595 model shows 8'h01, then 8'h80.
- Abort: assert reset after 4 srclk rises of 8'h0F, with the 595 model previously latched at 8'hAA → no rclk pulse, 595 outputs remain 8'hAA. The next full frame of 8'h55 latches 8'h55.
- DIV=1, WIDTH=16, data=16'h8001 → srclk period is 2 cycles. busy is high for 33 cycles. The bits sampled at srclk rising edges are 1, fourteen 0s, then 1.

Source files
------------

// File: rtl/hc595_driver.sv
// Serial driver for a chain of 74xx595 shift registers: shifts a WIDTH-bit word
// out MSB first on SER/SRCLK, then pulses RCLK once to latch the complete frame.
module hc595_driver #(
  parameter int WIDTH = 8,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             ser,
  output logic             srclk,
  output logic             rclk
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LATCH} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_shift, w_shift_next;
  logic [BW-1:0]    r_bit, w_bit_next;
  logic [DW-1:0]    r_div, w_div_next;
  logic             r_ser, w_ser_next;
  logic             r_srclk, w_srclk_next;
  logic             r_rclk, w_rclk_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             w_div_end;

  assign w_div_end = (r_div == LAST_DIV);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_ser   <= 1'b0;
      r_srclk <= 1'b0;
      r_rclk  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_bit   <= w_bit_next;
      r_div   <= w_div_next;
      r_ser   <= w_ser_next;
      r_srclk <= w_srclk_next;
      r_rclk  <= w_rclk_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (load) w_state_next = S_SETUP;
      S_SETUP: if (w_div_end) w_state_next = S_HIGH;
      S_HIGH:  if (w_div_end) w_state_next = (r_bit == LAST_BIT) ? S_LATCH : S_SETUP;
      S_LATCH: if (w_div_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    w_ser_next   = r_ser;
    w_srclk_next = r_srclk;
    w_rclk_next  = r_rclk;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    // The divider free-runs in every busy state and wraps on each phase change.
    if (r_state == S_IDLE || w_div_end) w_div_next = '0;
    else w_div_next = r_div + DW'(1);
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_shift_next = data;
          w_ser_next   = data[WIDTH-1];
          w_busy_next  = 1'b1;
          w_bit_next   = '0;
        end
      end
      S_SETUP: begin
        if (w_div_end) w_srclk_next = 1'b1;
      end
      S_HIGH: begin
        if (w_div_end) begin
          w_srclk_next = 1'b0;
          if (r_bit == LAST_BIT) begin
            w_rclk_next = 1'b1;
          end else begin
            // ser moves only together with the falling srclk edge.
            w_shift_next = r_shift << 1;
            w_ser_next   = w_shift_next[WIDTH-1];
            w_bit_next   = r_bit + BW'(1);
          end
        end
      end
      S_LATCH: begin
        if (w_div_end) begin
          w_rclk_next = 1'b0;
          w_busy_next = 1'b0;
          w_done_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign ser   = r_ser;
  assign srclk = r_srclk;
  assign rclk  = r_rclk;

endmodule

// File: tb/tb_hc595_driver.sv
// Bench for hc595_driver: an 8-bit/DIV=2 and a 16-bit/DIV=1 instance, checked every
// cycle against an offset-based waveform model, plus directed checks via a 595 chip model.
module tb_hc595_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_a = 1'b0, load_b = 1'b0;
  logic [7:0]  data_a = 8'h00;
  logic [15:0] data_b = 16'h0000;
  logic        busy_a, done_a, ser_a, srclk_a, rclk_a;
  logic        busy_b, done_b, ser_b, srclk_b, rclk_b;

  always #5 clk = ~clk;

  hc595_driver #(.WIDTH(8), .DIV(2)) dut_a (
    .clk(clk), .reset(reset), .data(data_a), .load(load_a),
    .busy(busy_a), .done(done_a), .ser(ser_a), .srclk(srclk_a), .rclk(rclk_a));

  hc595_driver #(.WIDTH(16), .DIV(1)) dut_b (
    .clk(clk), .reset(reset), .data(data_b), .load(load_b),
    .busy(busy_b), .done(done_b), .ser(ser_b), .srclk(srclk_b), .rclk(rclk_b));

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  // ---------------- waveform model: outputs as a function of cycles since accept
  localparam int BA = 2 * 2 * 8 + 2;
  localparam int BB = 2 * 1 * 16 + 1;
  bit          act_a = 0, act_b = 0;
  int          k_a = 0, k_b = 0;
  logic [15:0] dat_a = '0, dat_b = '0;

  function automatic logic [4:0] exp_out(input int w, input int d, input logic [15:0] dat,
                                          input int k, input bit act);
    logic s, sc, rc, b, dn;
    int bt;
    if (!act) return 5'b0;
    bt = 2 * d * w + d;
    if (k < 2 * d * w) begin
      s  = dat[w - 1 - k / (2 * d)];
      sc = (k % (2 * d)) >= d;
      rc = 1'b0;
    end else begin
      s  = dat[0];
      sc = 1'b0;
      rc = (k < bt);
    end
    b  = (k < bt);
    dn = (k == bt);
    return {s, sc, rc, b, dn};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      act_a <= 0; k_a <= 0; act_b <= 0; k_b <= 0;
    end else begin
      if (!(act_a && k_a < BA) && load_a) begin
        act_a <= 1; k_a <= 0; dat_a <= {8'h00, data_a};
      end else if (act_a && k_a < 1000) k_a <= k_a + 1;
      if (!(act_b && k_b < BB) && load_b) begin
        act_b <= 1; k_b <= 0; dat_b <= data_b;
      end else if (act_b && k_b < 1000) k_b <= k_b + 1;
    end
  end

  always @(negedge clk) begin
    logic [4:0] ea, eb;
    if (cmp_en) begin
      ea = exp_out(8, 2, dat_a, k_a, act_a);
      eb = exp_out(16, 1, dat_b, k_b, act_b);
      n_cmp++;
      if ({ser_a, srclk_a, rclk_a, busy_a, done_a} !== ea) begin
        n_fail++;
        $display("FAIL wave_a t=%0t {ser,srclk,rclk,busy,done} got %b want %b", $time,
                 {ser_a, srclk_a, rclk_a, busy_a, done_a}, ea);
      end
      n_cmp++;
      if ({ser_b, srclk_b, rclk_b, busy_b, done_b} !== eb) begin
        n_fail++;
        $display("FAIL wave_b t=%0t {ser,srclk,rclk,busy,done} got %b want %b", $time,
                 {ser_b, srclk_b, rclk_b, busy_b, done_b}, eb);
      end
    end
  end

  // ---------------- 595 chip models and activity counters
  logic [7:0]  sr_a = '0, lat_a = '0;
  logic [15:0] sr_b = '0, lat_b = '0;
  int rises_a = 0, rises_b = 0, lpulse_a = 0, lpulse_b = 0;
  int busyc_a = 0, busyc_b = 0, donec_a = 0, donec_b = 0;
  int rclkc_a = 0, rclkc_b = 0, srhi_b = 0;

  always @(posedge srclk_a) begin sr_a <= {sr_a[6:0], ser_a}; rises_a <= rises_a + 1; end
  always @(posedge rclk_a)  begin lat_a <= sr_a; lpulse_a <= lpulse_a + 1; end
  always @(posedge srclk_b) begin sr_b <= {sr_b[14:0], ser_b}; rises_b <= rises_b + 1; end
  always @(posedge rclk_b)  begin lat_b <= sr_b; lpulse_b <= lpulse_b + 1; end

  always @(negedge clk) begin
    if (busy_a === 1'b1) busyc_a <= busyc_a + 1;
    if (done_a === 1'b1) donec_a <= donec_a + 1;
    if (rclk_a === 1'b1) rclkc_a <= rclkc_a + 1;
    if (busy_b === 1'b1) busyc_b <= busyc_b + 1;
    if (done_b === 1'b1) donec_b <= donec_b + 1;
    if (rclk_b === 1'b1) rclkc_b <= rclkc_b + 1;
    if (srclk_b === 1'b1) srhi_b <= srhi_b + 1;
  end

  // ---------------- helpers
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got 0x%0h want 0x%0h", nm, got, want);
    end else
      $display("ok   %s = 0x%0h", nm, got);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input bit sel, input string nm);
    int n;
    n = 0;
    while (!((sel ? done_b : done_a) === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout waiting for done", nm);
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    data_a = d; load_a = 1'b1;
    tick(1);
    load_a = 1'b0;
  endtask

  int b_rise, b_busy, b_done, b_lp, b_rclk, b_srhi, n;

  initial begin
    // reset state
    tick(3);
    cmp_en = 1;
    check("reset_outs_a", {ser_a, srclk_a, rclk_a, busy_a, done_a}, 0);
    check("reset_outs_b", {ser_b, srclk_b, rclk_b, busy_b, done_b}, 0);
    reset = 1'b0;
    tick(5);
    check("idle_after_reset", {busy_a, srclk_a, rclk_a, busy_b, srclk_b}, 0);
    check("idle_no_rises", rises_a + rises_b, 0);

    // single frame 8'hA5
    b_rise = rises_a; b_busy = busyc_a; b_done = donec_a; b_lp = lpulse_a; b_rclk = rclkc_a;
    data_a = 8'hA5; load_a = 1'b1;
    tick(1);
    load_a = 1'b0;
    check("a5_first_busy", busy_a, 1);
    check("a5_first_ser", ser_a, 1);
    wait_done(0, "a5");
    tick(2);
    check("a5_rises", rises_a - b_rise, 8);
    check("a5_sampled_bits", sr_a, 8'hA5);
    check("a5_busy_cycles", busyc_a - b_busy, 34);
    check("a5_done_pulses", donec_a - b_done, 1);
    check("a5_rclk_high_cycles", rclkc_a - b_rclk, 2);
    check("a5_latched", lat_a, 8'hA5);
    check("a5_ser_holds_lsb", ser_a, 1);

    // load while busy is dropped
    b_rise = rises_a; b_done = donec_a; b_lp = lpulse_a;
    send_a(8'hFF);
    tick(9);
    send_a(8'h3C);
    wait_done(0, "ff");
    tick(5);
    check("busyload_rises", rises_a - b_rise, 8);
    check("busyload_latched", lat_a, 8'hFF);
    check("busyload_one_latch", lpulse_a - b_lp, 1);
    check("busyload_idle", busy_a, 0);

    // back-to-back frames with load held
    data_a = 8'h01; load_a = 1'b1;
    wait_done(0, "b2b_1");
    check("b2b_first_latched", lat_a, 8'h01);
    data_a = 8'h80;
    tick(1);
    check("b2b_one_idle_busy", busy_a, 1);
    check("b2b_second_ser", ser_a, 1);
    load_a = 1'b0;
    wait_done(0, "b2b_2");
    tick(1);
    check("b2b_second_latched", lat_a, 8'h80);

    // abort mid-frame
    send_a(8'hAA);
    wait_done(0, "aa");
    tick(1);
    check("abort_pre_latched", lat_a, 8'hAA);
    b_lp = lpulse_a; b_rise = rises_a;
    send_a(8'h0F);
    n = 0;
    while (rises_a - b_rise < 4 && n < 100) begin tick(1); n++; end
    check("abort_rise_wait", rises_a - b_rise, 4);
    tick(2);
    check("abort_pre_busy_ser", {busy_a, ser_a}, 2'b11);
    #2 reset = 1'b1;
    #1 check("abort_async_outs", {ser_a, srclk_a, rclk_a, busy_a, done_a}, 0);
    tick(2);
    reset = 1'b0;
    tick(4);
    check("abort_no_latch", lpulse_a - b_lp, 0);
    check("abort_kept_word", lat_a, 8'hAA);
    check("abort_idle", busy_a, 0);
    send_a(8'h55);
    wait_done(0, "55");
    tick(1);
    check("abort_next_latched", lat_a, 8'h55);

    // DIV=1, WIDTH=16
    b_rise = rises_b; b_busy = busyc_b; b_rclk = rclkc_b; b_srhi = srhi_b; b_done = donec_b;
    data_b = 16'h8001; load_b = 1'b1;
    tick(1);
    load_b = 1'b0;
    wait_done(1, "w16");
    tick(2);
    check("w16_busy_cycles", busyc_b - b_busy, 33);
    check("w16_rises", rises_b - b_rise, 16);
    check("w16_srclk_high_cycles", srhi_b - b_srhi, 16);
    check("w16_sampled_bits", sr_b, 16'h8001);
    check("w16_rclk_high_cycles", rclkc_b - b_rclk, 1);
    check("w16_latched", lat_b, 16'h8001);
    check("w16_done_pulses", donec_b - b_done, 1);

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
